mem_port_arbiter: RTL

Two-master, one-slave arbiter that lets two sort controllers share a single memory port built from AR/R/AW/W/B valid-ready channels.
- Exactly one master owns the slave port per transaction (one read, or one write), from request through final response.
- Ownership changes only between transactions; arbitration is round-robin by default.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter_rr_pick2.sv | 18 +
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned STATE_WDTH  = 3;
  localparam int unsigned NUM_MASTERS = 2;

  typedef enum logic [STATE_WDTH-1:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Master-side (two sort controllers) and slave-side (memory) valid/ready channels.
// slave modport is the arbiter's view; master modport is the surrounding environment.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WDTH = 4,
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned RESP_WDTH = 1
);
  logic [NUM_MASTERS-1:0]           m_ar_valid, m_ar_ready;
  logic [NUM_MASTERS*ADDR_WDTH-1:0] m_ar_addr;
  logic [NUM_MASTERS-1:0]           m_r_valid, m_r_ready;
  logic [NUM_MASTERS*DATA_WDTH-1:0] m_r_data;
  logic [NUM_MASTERS-1:0]           m_aw_valid, m_aw_ready;
  logic [NUM_MASTERS*ADDR_WDTH-1:0] m_aw_addr;
  logic [NUM_MASTERS-1:0]           m_w_valid, m_w_ready;
  logic [NUM_MASTERS*DATA_WDTH-1:0] m_w_data;
  logic [NUM_MASTERS-1:0]           m_b_valid, m_b_ready;
  logic [NUM_MASTERS*RESP_WDTH-1:0] m_b_resp;

  logic                 s_ar_valid, s_ar_ready;
  logic [ADDR_WDTH-1:0] s_ar_addr;
  logic                 s_r_valid, s_r_ready;
  logic [DATA_WDTH-1:0] s_r_data;
  logic                 s_aw_valid, s_aw_ready;
  logic [ADDR_WDTH-1:0] s_aw_addr;
  logic                 s_w_valid, s_w_ready;
  logic [DATA_WDTH-1:0] s_w_data;
  logic                 s_b_valid, s_b_ready;
  logic [RESP_WDTH-1:0] s_b_resp;

  modport slave (
    input  m_ar_valid, m_ar_addr, m_r_ready, m_aw_valid, m_aw_addr, m_w_valid, m_w_data,
           m_b_ready, s_ar_ready, s_r_valid, s_r_data, s_aw_ready, s_w_ready, s_b_valid,
           s_b_resp,
    output m_ar_ready, m_r_valid, m_r_data, m_aw_ready, m_w_ready, m_b_valid, m_b_resp,
           s_ar_valid, s_ar_addr, s_r_ready, s_aw_valid, s_aw_addr, s_w_valid, s_w_data,
           s_b_ready
  );

  modport master (
    output m_ar_valid, m_ar_addr, m_r_ready, m_aw_valid, m_aw_addr, m_w_valid, m_w_data,
           m_b_ready, s_ar_ready, s_r_valid, s_r_data, s_aw_ready, s_w_ready, s_b_valid,
           s_b_resp,
    input  m_ar_ready, m_r_valid, m_r_data, m_aw_ready, m_w_ready, m_b_valid, m_b_resp,
           s_ar_valid, s_ar_addr, s_r_ready, s_aw_valid, s_aw_addr, s_w_valid, s_w_data,
           s_b_ready
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-request winner selection: round-robin against last_grant, or master 0
// always first when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_o,
  output logic       any_o
);
  always_comb begin
    any_o = |req_i;
`ifdef MEM_ARB_FIXED_PRIO_EN
    gnt_o = ~req_i[0];
`else
    if (&req_i) gnt_o = ~last_grant_i;
    else        gnt_o = req_i[1];
`endif
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master / one-slave memory port arbiter; one owner per read or write transaction.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins) instead of round-robin.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WDTH = 4,
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned RESP_WDTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic              grant
);
  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       pick_idx, pick_any;
  logic       aw_hs, w_hs;

  rr_pick2 u_pick (
    .req_i       (bus.m_ar_valid | bus.m_aw_valid),
    .last_grant_i(last_grant_q),
    .gnt_o       (pick_idx),
    .any_o       (pick_any)
  );

  assign grant = grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  always_comb begin
    bus.m_ar_ready = '0;
    bus.m_r_valid  = '0;
    bus.m_r_data   = '0;
    bus.m_aw_ready = '0;
    bus.m_w_ready  = '0;
    bus.m_b_valid  = '0;
    bus.m_b_resp   = '0;
    bus.s_ar_valid = 1'b0;
    bus.s_ar_addr  = '0;
    bus.s_r_ready  = 1'b0;
    bus.s_aw_valid = 1'b0;
    bus.s_aw_addr  = '0;
    bus.s_w_valid  = 1'b0;
    bus.s_w_data   = '0;
    bus.s_b_ready  = 1'b0;
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    aw_hs          = 1'b0;
    w_hs           = 1'b0;

    unique case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = bus.m_ar_valid[pick_idx] ? RD_ADDR : WR_REQ;
        end
      end
      RD_ADDR: begin
        bus.s_ar_valid          = bus.m_ar_valid[grant_q];
        bus.s_ar_addr           = bus.m_ar_addr[grant_q*ADDR_WDTH +: ADDR_WDTH];
        bus.m_ar_ready[grant_q] = bus.s_ar_ready;
        if (bus.m_ar_valid[grant_q] && bus.s_ar_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        bus.m_r_valid[grant_q]                        = bus.s_r_valid;
        bus.m_r_data[grant_q*DATA_WDTH +: DATA_WDTH]  = bus.s_r_data;
        bus.s_r_ready                                 = bus.m_r_ready[grant_q];
        if (bus.s_r_valid && bus.m_r_ready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; a channel goes quiet once its flag is set
        bus.s_aw_valid          = bus.m_aw_valid[grant_q] & ~aw_done_q;
        bus.s_aw_addr           = bus.m_aw_addr[grant_q*ADDR_WDTH +: ADDR_WDTH];
        bus.m_aw_ready[grant_q] = bus.s_aw_ready & ~aw_done_q;
        bus.s_w_valid           = bus.m_w_valid[grant_q] & ~w_done_q;
        bus.s_w_data            = bus.m_w_data[grant_q*DATA_WDTH +: DATA_WDTH];
        bus.m_w_ready[grant_q]  = bus.s_w_ready & ~w_done_q;
        aw_hs     = bus.m_aw_valid[grant_q] & ~aw_done_q & bus.s_aw_ready;
        w_hs      = bus.m_w_valid[grant_q] & ~w_done_q & bus.s_w_ready;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        bus.m_b_valid[grant_q]                       = bus.s_b_valid;
        bus.m_b_resp[grant_q*RESP_WDTH +: RESP_WDTH] = bus.s_b_resp;
        bus.s_b_ready                                = bus.m_b_ready[grant_q];
        if (bus.s_b_valid && bus.m_b_ready[grant_q]) begin
          last_grant_d = grant_q;
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
